// File: rtl/ucie_ctl_csr_apb_master.sv
// Protocol-side initiator for the UCIe controller CSR port: one command at a time is
// sequenced through SETUP and ACCESS phases, with a bounded wait for the slave's ready.
module ucie_ctl_csr_apb_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERRCNT_W       = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_wr,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_P_Select,
    output logic                o_P_Enable,
    output logic                o_P_WR,
    output logic [ADDR_W-1:0]   o_P_addr,
    output logic [DATA_W-1:0]   o_P_WDATA,
    input  logic                i_P_Ready,
    input  logic [DATA_W-1:0]   i_P_RDATA,
    output logic                o_busy,
    output logic [ERRCNT_W-1:0] o_err_count
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    tmo_cnt_r;
    logic [CNT_W-1:0]    tmo_cnt_s;
    logic [CNT_W-1:0]    tmo_inc_s;
    logic                cmd_ready_s;
    logic                rsp_valid_s;
    logic [DATA_W-1:0]   rsp_rdata_s;
    logic                rsp_err_s;
    logic                sel_s;
    logic                en_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [ERRCNT_W-1:0] err_count_s;

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        tmo_cnt_s   = tmo_cnt_r;
        tmo_inc_s   = tmo_cnt_r + CNT_W'(1);
        cmd_ready_s = 1'b0;
        rsp_valid_s = o_rsp_valid;
        rsp_rdata_s = o_rsp_rdata;
        rsp_err_s   = o_rsp_err;
        sel_s       = 1'b0;
        en_s        = 1'b0;
        wr_s        = o_P_WR;
        addr_s      = o_P_addr;
        wdata_s     = o_P_WDATA;
        err_count_s = o_err_count;
        case (state_r)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    state_s   = ST_SETUP;
                    tmo_cnt_s = {CNT_W{1'b0}};
                    sel_s     = 1'b1;
                    wr_s      = i_cmd_wr;
                    addr_s    = i_cmd_addr;
                    wdata_s   = i_cmd_wdata;
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
                sel_s   = 1'b1;
                en_s    = 1'b1;
            end
            ST_ACCESS: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (i_P_Ready) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = o_P_WR ? {DATA_W{1'b0}} : i_P_RDATA;
                    rsp_err_s   = 1'b0;
                end else if (TMO_EN && (tmo_inc_s == TMO_LIMIT)) begin
                    state_s     = ST_RESP;
                    tmo_cnt_s   = tmo_inc_s;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                    rsp_err_s   = 1'b1;
                    err_count_s = (o_err_count == {ERRCNT_W{1'b1}}) ?
                                  o_err_count : o_err_count + ERRCNT_W'(1);
                end else begin
                    tmo_cnt_s = TMO_EN ? tmo_inc_s : tmo_cnt_r;
                    sel_s     = 1'b1;
                    en_s      = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
                cmd_ready_s = 1'b1;
            end
        endcase
    end

    // State, timeout counter and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= {CNT_W{1'b0}};
            o_cmd_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= {DATA_W{1'b0}};
            o_rsp_err   <= 1'b0;
            o_P_Select  <= 1'b0;
            o_P_Enable  <= 1'b0;
            o_P_WR      <= 1'b0;
            o_P_addr    <= {ADDR_W{1'b0}};
            o_P_WDATA   <= {DATA_W{1'b0}};
            o_busy      <= 1'b0;
            o_err_count <= {ERRCNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            tmo_cnt_r   <= tmo_cnt_s;
            o_cmd_ready <= cmd_ready_s;
            o_rsp_valid <= rsp_valid_s;
            o_rsp_rdata <= rsp_rdata_s;
            o_rsp_err   <= rsp_err_s;
            o_P_Select  <= sel_s;
            o_P_Enable  <= en_s;
            o_P_WR      <= wr_s;
            o_P_addr    <= addr_s;
            o_P_WDATA   <= wdata_s;
            o_busy      <= (state_s != ST_IDLE);
            o_err_count <= err_count_s;
        end
    end

endmodule

// File: tb/tb_ucie_ctl_csr_apb_master.sv
// Directed bench for ucie_ctl_csr_apb_master with a small CSR slave model
// (configurable wait states, stuck-not-ready, read-only bit mask at 0x10).
module tb_ucie_ctl_csr_apb_master;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_wr;
    logic [7:0]  i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_P_Select;
    logic        o_P_Enable;
    logic        o_P_WR;
    logic [7:0]  o_P_addr;
    logic [31:0] o_P_WDATA;
    logic        i_P_Ready;
    logic [31:0] i_P_RDATA;
    logic        o_busy;
    logic [7:0]  o_err_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    int          slv_wait;
    logic        slv_stuck;
    int          acc_cnt;

    ucie_ctl_csr_apb_master #(
        .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(16), .ERRCNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_P_Select(o_P_Select), .o_P_Enable(o_P_Enable), .o_P_WR(o_P_WR),
        .o_P_addr(o_P_addr), .o_P_WDATA(o_P_WDATA),
        .i_P_Ready(i_P_Ready), .i_P_RDATA(i_P_RDATA),
        .o_busy(o_busy), .o_err_count(o_err_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] wmask(input logic [7:0] a);
        return (a == 8'h10) ? 32'h001F_FC03 : 32'hFFFF_FFFF;
    endfunction

    assign i_P_Ready = o_P_Select & o_P_Enable & ~slv_stuck & (acc_cnt == slv_wait);
    assign i_P_RDATA = mem[o_P_addr];

    // CSR slave model: counts wait states and commits masked writes.
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_cnt   <= 0;
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h20] <= 32'h0000_0011;
        end else begin
            if (o_P_Select && o_P_Enable && !i_P_Ready) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (o_P_Select && o_P_Enable && i_P_Ready && o_P_WR)
                mem[o_P_addr] <= o_P_WDATA & wmask(o_P_addr);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one command with i_rsp_ready held high; returns response and ACCESS-cycle count.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int en_cyc, output logic done);
        logic acc;
        done = 1'b0; en_cyc = 0; rdata = 32'h0; err = 1'b0; acc = 1'b0;
        i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wdata;
        i_cmd_valid = 1'b1; i_rsp_ready = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = o_cmd_ready;
            step();
        end
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (o_P_Select && o_P_Enable) en_cyc++;
            if (o_rsp_valid) begin
                rdata = o_rsp_rdata; err = o_rsp_err; done = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = 8'h00;
        i_cmd_wdata = 32'h0; i_rsp_ready = 1'b0; slv_wait = 0; slv_stuck = 1'b0;
        step(); step(); step();
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0h exp=1", o_cmd_ready); end
        checks++; if (o_P_Select !== 1'b0) begin errors++; $display("FAIL reset_select got=%0h exp=0", o_P_Select); end
        checks++; if (o_P_Enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0h exp=0", o_P_Enable); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0h exp=0", o_rsp_valid); end
        checks++; if (o_err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got=%0h exp=0", o_err_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", o_busy); end
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_readback();
        logic [31:0] rd; logic er; int ec; logic dn;
        i_cmd_wr = 1'b1; i_cmd_addr = 8'h10; i_cmd_wdata = 32'hFFFF_FFFF;
        i_cmd_valid = 1'b1; i_rsp_ready = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        checks++; if (o_P_Select !== 1'b1 || o_P_Enable !== 1'b0) begin errors++; $display("FAIL wr_setup sel/en got=%0h/%0h exp=1/0", o_P_Select, o_P_Enable); end
        checks++; if (o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL wr_setup ready/busy got=%0h/%0h exp=0/1", o_cmd_ready, o_busy); end
        step();
        checks++; if (o_P_Select !== 1'b1 || o_P_Enable !== 1'b1) begin errors++; $display("FAIL wr_access sel/en got=%0h/%0h exp=1/1", o_P_Select, o_P_Enable); end
        checks++; if (o_P_WR !== 1'b1 || o_P_addr !== 8'h10 || o_P_WDATA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wr_access bus got=%0h/%0h/%0h exp=1/10/ffffffff", o_P_WR, o_P_addr, o_P_WDATA); end
        step();
        checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp valid/rdata/err got=%0h/%0h/%0h exp=1/0/0", o_rsp_valid, o_rsp_rdata, o_rsp_err); end
        checks++; if (o_P_Select !== 1'b0 || o_P_Enable !== 1'b0) begin errors++; $display("FAIL wr_rsp sel/en got=%0h/%0h exp=0/0", o_P_Select, o_P_Enable); end
        checks++; if (o_P_addr !== 8'h10) begin errors++; $display("FAIL wr_rsp addr_hold got=%0h exp=10", o_P_addr); end
        step();
        checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL wr_done valid/ready/busy got=%0h/%0h/%0h exp=0/1/0", o_rsp_valid, o_cmd_ready, o_busy); end
        run_cmd(1'b0, 8'h10, 32'h0, rd, er, ec, dn);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL rb_done got=%0h exp=1", dn); end
        checks++; if (rd !== 32'h001F_FC03 || er !== 1'b0) begin errors++; $display("FAIL rb_data got=%h err=%0h exp=001ffc03 err=0", rd, er); end
    endtask

    task automatic test_read_wait();
        logic [31:0] rd; logic er; int ec; logic dn;
        slv_wait = 3;
        run_cmd(1'b0, 8'h20, 32'h0, rd, er, ec, dn);
        slv_wait = 0;
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL rdwait_done got=%0h exp=1", dn); end
        checks++; if (ec != 4) begin errors++; $display("FAIL rdwait_enable_cycles got=%0d exp=4", ec); end
        checks++; if (rd !== 32'h0000_0011 || er !== 1'b0) begin errors++; $display("FAIL rdwait_data got=%h err=%0h exp=00000011 err=0", rd, er); end
    endtask

    task automatic test_ready_wins();
        logic [31:0] rd; logic er; int ec; logic dn;
        slv_wait = 15;
        run_cmd(1'b0, 8'h20, 32'h0, rd, er, ec, dn);
        slv_wait = 0;
        checks++; if (dn !== 1'b1 || ec != 16) begin errors++; $display("FAIL rdywin_cycles done=%0h got=%0d exp=16", dn, ec); end
        checks++; if (rd !== 32'h0000_0011 || er !== 1'b0) begin errors++; $display("FAIL rdywin_data got=%h err=%0h exp=00000011 err=0", rd, er); end
        checks++; if (o_err_count !== 8'h00) begin errors++; $display("FAIL rdywin_err_count got=%0h exp=0", o_err_count); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int ec; logic dn;
        int bad;
        slv_stuck = 1'b1;
        run_cmd(1'b0, 8'h20, 32'h0, rd, er, ec, dn);
        checks++; if (dn !== 1'b1 || ec != 16) begin errors++; $display("FAIL tmo_cycles done=%0h got=%0d exp=16", dn, ec); end
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL tmo_rsp err=%0h rdata=%h exp err=1 rdata=0", er, rd); end
        checks++; if (o_err_count !== 8'h01) begin errors++; $display("FAIL tmo_err_count1 got=%0h exp=1", o_err_count); end
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            run_cmd(1'b0, 8'h30, 32'h0, rd, er, ec, dn);
            if (dn !== 1'b1 || er !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tmo_repeat bad_responses got=%0d exp=0", bad); end
        checks++; if (o_err_count !== 8'hFF) begin errors++; $display("FAIL tmo_err_count_sat got=%0h exp=ff", o_err_count); end
        slv_stuck = 1'b0;
    endtask

    task automatic test_backpressure();
        logic seen;
        seen = 1'b0;
        i_cmd_wr = 1'b0; i_cmd_addr = 8'h20; i_cmd_wdata = 32'h0;
        i_cmd_valid = 1'b1; i_rsp_ready = 1'b0;
        step();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (o_rsp_valid) seen = 1'b1;
            else step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_rsp_seen got=%0h exp=1", seen); end
        i_cmd_wr = 1'b1; i_cmd_addr = 8'h14; i_cmd_wdata = 32'h0000_0055; i_cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h11 || o_rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] valid/rdata/err got=%0h/%h/%0h exp=1/00000011/0", i, o_rsp_valid, o_rsp_rdata, o_rsp_err); end
            checks++; if (o_cmd_ready !== 1'b0 || o_P_Select !== 1'b0) begin errors++; $display("FAIL bp_block[%0d] ready/sel got=%0h/%0h exp=0/0", i, o_cmd_ready, o_P_Select); end
            step();
        end
        i_rsp_ready = 1'b1;
        step();
        checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_P_Select !== 1'b0) begin errors++; $display("FAIL bp_handshake valid/ready/sel got=%0h/%0h/%0h exp=0/1/0", o_rsp_valid, o_cmd_ready, o_P_Select); end
        step();
        checks++; if (o_P_Select !== 1'b1 || o_P_addr !== 8'h14 || o_P_WR !== 1'b1) begin errors++; $display("FAIL bp_accept sel/addr/wr got=%0h/%0h/%0h exp=1/14/1", o_P_Select, o_P_addr, o_P_WR); end
        i_cmd_valid = 1'b0; i_cmd_addr = 8'h99; i_cmd_wr = 1'b0; i_cmd_wdata = 32'hAAAA_AAAA;
        step();
        checks++; if (o_P_Enable !== 1'b1 || o_P_addr !== 8'h14 || o_P_WR !== 1'b1 || o_P_WDATA !== 32'h55) begin errors++; $display("FAIL bp_cmd_stable en/addr/wr/wdata got=%0h/%0h/%0h/%h exp=1/14/1/00000055", o_P_Enable, o_P_addr, o_P_WR, o_P_WDATA); end
        step();
        checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin errors++; $display("FAIL bp_wr_rsp valid/rdata/err got=%0h/%h/%0h exp=1/0/0", o_rsp_valid, o_rsp_rdata, o_rsp_err); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int ec; logic dn; logic saw;
        slv_stuck = 1'b1;
        i_cmd_wr = 1'b0; i_cmd_addr = 8'h30; i_cmd_valid = 1'b1; i_rsp_ready = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        step(); step();
        checks++; if (o_P_Enable !== 1'b1) begin errors++; $display("FAIL mid_in_access en got=%0h exp=1", o_P_Enable); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_P_Select !== 1'b0 || o_P_Enable !== 1'b0) begin errors++; $display("FAIL mid_reset sel/en got=%0h/%0h exp=0/0", o_P_Select, o_P_Enable); end
        checks++; if (o_err_count !== 8'h00 || o_cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset errcnt/ready got=%0h/%0h exp=0/1", o_err_count, o_cmd_ready); end
        step();
        i_rst_n = 1'b1; slv_stuck = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_rsp_valid) saw = 1'b1;
            step();
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got=%0h exp=0", saw); end
        run_cmd(1'b1, 8'h14, 32'h1234_5678, rd, er, ec, dn);
        checks++; if (dn !== 1'b1 || er !== 1'b0 || rd !== 32'h0 || ec != 1) begin errors++; $display("FAIL mid_next_wr done=%0h err=%0h rdata=%h cyc=%0d exp 1/0/0/1", dn, er, rd, ec); end
        run_cmd(1'b0, 8'h14, 32'h0, rd, er, ec, dn);
        checks++; if (dn !== 1'b1 || rd !== 32'h1234_5678) begin errors++; $display("FAIL mid_readback done=%0h got=%h exp=12345678", dn, rd); end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_read_wait();
        test_ready_wins();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_csr_apb_master.md
Name: ucie_ctl_csr_apb_master

Overview:
Protocol-side initiator that drives the UCIe controller CSR block's APB-style register port (Select/Enable/Ready).
- Accepts single register read/write commands from the protocol layer on a valid/ready interface.
- Sequences them as SETUP then ACCESS phases on the CSR port.
- Returns read data and completion status on a held response channel.
- Bounds every access with a timeout.

Parameters:
ADDR_W, 8, CSR address width
DATA_W, 32, CSR data width
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for i_P_Ready; 0 disables the timeout
ERRCNT_W, 8, width of saturating error counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  command accepted when valid&ready
i_cmd_wr  input  1  1 write, 0 read
i_cmd_addr  input  ADDR_W  register address
i_cmd_wdata  input  DATA_W  write data
o_rsp_valid  output  1  completion available
i_rsp_ready  input  1  completion consumed when valid&ready
o_rsp_rdata  output  DATA_W  read data (0 for writes and on error)
o_rsp_err  output  1  1 = access timed out
o_P_Select  output  1  CSR select
o_P_Enable  output  1  CSR access-phase enable
o_P_WR  output  1  1 write, 0 read
o_P_addr  output  ADDR_W  CSR address
o_P_WDATA  output  DATA_W  CSR write data
i_P_Ready  input  1  CSR ready/complete
i_P_RDATA  input  DATA_W  CSR read data
o_busy  output  1  high whenever state != IDLE
o_err_count  output  ERRCNT_W  saturating count of timed-out accesses

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs 0, except o_cmd_ready = 1.
  - o_err_count = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid, latch wr/addr/wdata into o_P_WR/o_P_addr/o_P_WDATA; next state SETUP.
- SETUP (exactly one cycle):
  - o_P_Select = 1, o_P_Enable = 0; next state ACCESS.
- ACCESS:
  - o_P_Select = 1, o_P_Enable = 1. The timeout counter increments each ACCESS cycle.
  - If i_P_Ready = 1 at a rising edge: capture o_rsp_rdata = (read ? i_P_RDATA : 0), o_rsp_err = 0, drop Select/Enable, assert o_rsp_valid, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: o_rsp_rdata = 0, o_rsp_err = 1, drop Select/Enable, o_err_count += 1 (saturates at all-ones), assert o_rsp_valid, go to RESP.
  - i_P_Ready sampled in the same edge as the timeout: Ready wins, no error.
- RESP:
  - o_rsp_valid, o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready.
  - On the handshake edge: o_rsp_valid = 0, go to IDLE.
  - o_cmd_ready stays 0 in RESP; no overlap of command and response.
- Latency (command edge = cycle 0, zero-wait slave):
  - SETUP in cycle 1, ACCESS in cycle 2.
  - o_rsp_valid high in cycle 3.
  - Next command accepted no earlier than the edge after the response handshake.
- Outside SETUP/ACCESS: o_P_Select = o_P_Enable = 0; o_P_addr/o_P_WDATA/o_P_WR hold their last values.
- i_P_Ready and i_P_RDATA are ignored outside ACCESS.
- i_cmd_* are sampled only at the accept edge; later changes have no effect on the active transaction.
- Timeout counter clears on entry to SETUP; it is wide enough for TIMEOUT_CYCLES with no wrap.
- Reset asserted mid-transaction: Select/Enable drop immediately, the pending response is discarded, o_err_count clears.

Test Plan:
- Reset with i_rst_n=0 -> o_cmd_ready=1, o_P_Select=0, o_P_Enable=0, o_rsp_valid=0, o_err_count=0.
- Write addr 0x10 data 0xFFFF_FFFF, slave Ready in first ACCESS cycle, i_rsp_ready=1 -> Select=1 on cycle 1, Enable=1 on cycle 2, o_rsp_valid on cycle 3 with rdata=0, err=0; CSR read-back of 0x10 via a following read returns 0x001F_FC03 (RO bits masked).
- Read addr 0x20 after reset, slave drives 0x0000_0011 with Ready after 3 wait cycles -> Enable held 4 cycles, o_rsp_rdata=0x11, err=0.
- Read with i_P_Ready stuck 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then o_rsp_err=1, rdata=0, o_err_count=1; 255 further timeouts with ERRCNT_W=8 leave o_err_count=0xFF.
- Response backpressure: i_rsp_ready=0 for 5 cycles with a new i_cmd_valid pending -> rsp fields stable, o_cmd_ready=0; command accepted only after the handshake.
- Reset pulse during ACCESS -> Select/Enable=0 immediately, no o_rsp_valid after release; next write to 0x14 completes normally.
